// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED scan sequencer.
package led_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] POS_MIN = 4'd1;
  localparam logic [3:0] POS_MAX = 4'd8;

endpackage

// File: rtl/led_scan_sequencer_tick_prescaler.sv
// Prescaler for automatic stepping: counts 0..TICK_DIV-1 while enabled, held at 0 otherwise.
module tick_prescaler #(
  parameter int TICK_DIV = 3125000
) (
  input  logic clk_25mhz,
  input  logic rst,
  input  logic en,
  output logic expire
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  // Clearing while disabled makes every entry to RUN start a full period.
  always_ff @(posedge clk_25mhz) begin
    if (rst || !en)      cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                 cnt <= cnt + W'(1);
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/led_scan_sequencer.sv
// Scans a single lit LED across positions 1..8 by driving the decoder's hex index.
// Build option: define LED_SCAN_BOUNCE_EN for ping-pong scanning (dir input ignored).
module led_scan_sequencer
  import led_scan_pkg::*;
#(
  parameter int TICK_DIV = 3125000
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic       run,
  input  logic       dir,
  input  logic       step,
  input  logic       blank,
  output logic [3:0] hex,
  output logic       tick,
  output logic       wrap
);

  state_t     state;
  logic [3:0] pos;
  logic [3:0] nxt;
  logic       turn;
  logic       adv;
  logic       expire;
  logic       blank_q;
  logic       tick_q;
  logic       wrap_q;
`ifdef LED_SCAN_BOUNCE_EN
  logic       bdir;
`endif

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk_25mhz (clk_25mhz),
    .rst       (rst),
    .en        (state == RUN),
    .expire    (expire)
  );

  // step is deliberately not considered in RUN, even when it lands on a tick.
  always_comb begin
    adv = 1'b0;
    if (state == RUN)        adv = expire;
    else if (state == PAUSE) adv = step;
  end

  always_comb begin
    nxt  = pos;
    turn = 1'b0;
`ifdef LED_SCAN_BOUNCE_EN
    if (!bdir) begin
      if (pos == POS_MAX) begin nxt = POS_MAX - 4'd1; turn = 1'b1; end
      else                      nxt = pos + 4'd1;
    end else begin
      if (pos == POS_MIN) begin nxt = POS_MIN + 4'd1; turn = 1'b1; end
      else                      nxt = pos - 4'd1;
    end
`else
    if (!dir) begin
      if (pos == POS_MAX) begin nxt = POS_MIN; turn = 1'b1; end
      else                      nxt = pos + 4'd1;
    end else begin
      if (pos == POS_MIN) begin nxt = POS_MAX; turn = 1'b1; end
      else                      nxt = pos - 4'd1;
    end
`endif
  end

  // Outputs trail pos by one stage; tick/wrap are delayed to line up with the new hex.
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      state   <= IDLE;
      pos     <= POS_MIN;
      blank_q <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      hex     <= 4'd0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
`ifdef LED_SCAN_BOUNCE_EN
      bdir    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:    if (run) state <= RUN; else if (step) state <= PAUSE;
        RUN:     if (!run) state <= PAUSE;
        PAUSE:   if (run) state <= RUN;
        default: state <= IDLE;
      endcase
      if (adv) begin
        pos <= nxt;
`ifdef LED_SCAN_BOUNCE_EN
        if (turn) bdir <= ~bdir;
`endif
      end
      tick_q  <= adv && (state == RUN);
      wrap_q  <= adv && turn;
      blank_q <= blank;
      hex     <= (blank_q || state == IDLE) ? 4'd0 : pos;
      tick    <= tick_q;
      wrap    <= wrap_q;
    end
  end

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Directed bench for led_scan_sequencer with TICK_DIV=4 (plus a TICK_DIV=1 instance).
module tb_led_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, dir, step, blank;
  logic [3:0] hex, hex1;
  logic       tick, wrap, tick1, wrap1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_scan_sequencer #(.TICK_DIV(4)) dut (
    .clk_25mhz(clk), .rst(rst), .run(run), .dir(dir), .step(step),
    .blank(blank), .hex(hex), .tick(tick), .wrap(wrap)
  );

  led_scan_sequencer #(.TICK_DIV(1)) dut1 (
    .clk_25mhz(clk), .rst(rst), .run(run), .dir(dir), .step(step),
    .blank(blank), .hex(hex1), .tick(tick1), .wrap(wrap1)
  );

  typedef struct {
    logic       run;
    logic       dir;
    logic       step;
    logic       blank;
    logic [3:0] hex;
    logic       tick;
    logic       wrap;
  } vec_t;

  vec_t tbl[37];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; dir = 1'b0; step = 1'b0; blank = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic pulse_step(input logic d, input int exp_hex, input int exp_wrap, input string name);
    dir = d; step = 1'b1; cyc();
    step = 1'b0; cyc();
    chk({name, " hex"}, hex, exp_hex);
    chk({name, " wrap"}, wrap, exp_wrap);
    chk({name, " tick"}, tick, 0);
  endtask

  initial begin
    // Row k: inputs held before edge k (counted from the run edge), outputs after it.
    for (int k = 0; k < 37; k++) begin
      int p;
      p = (k + 3) / 4;
      if (p == 9) begin
`ifdef LED_SCAN_BOUNCE_EN
        p = 7;
`else
        p = 1;
`endif
      end
      tbl[k].run   = 1'b1;
      tbl[k].dir   = 1'b0;
      tbl[k].step  = 1'b0;
      tbl[k].blank = 1'b0;
      tbl[k].hex   = (k == 0) ? 4'd0 : 4'(p);
      tbl[k].tick  = (k >= 5) && ((k - 1) % 4 == 0);
      tbl[k].wrap  = (k == 33);
    end

    // Reset state and idling
    do_reset();
    chk("reset hex", hex, 0);
    chk("reset tick", tick, 0);
    chk("reset wrap", wrap, 0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("idle hex", hex, 0);
      chk("idle tick", tick, 0);
      chk("idle wrap", wrap, 0);
    end

    // Automatic scan up, one step per 4 cycles, through the 8 -> 1 (or 8 -> 7) wrap
    for (int k = 0; k < 37; k++) begin
      run = tbl[k].run; dir = tbl[k].dir; step = tbl[k].step; blank = tbl[k].blank;
      cyc();
      chk($sformatf("scan[%0d] hex", k), hex, tbl[k].hex);
      chk($sformatf("scan[%0d] tick", k), tick, tbl[k].tick);
      chk($sformatf("scan[%0d] wrap", k), wrap, tbl[k].wrap);
      if (k >= 1 && k <= 3) chk($sformatf("div1[%0d] hex", k), hex1, k);
    end

    // Manual stepping from PAUSE at pos 1 with dir = 1
    do_reset();
    step = 1'b1; cyc();
    step = 1'b0; cyc();
    chk("pause entry hex", hex, 1);
`ifdef LED_SCAN_BOUNCE_EN
    pulse_step(1'b1, 2, 0, "step1");
    pulse_step(1'b1, 3, 0, "step2");
    pulse_step(1'b1, 4, 0, "step3");
`else
    pulse_step(1'b1, 8, 1, "step1");
    pulse_step(1'b1, 7, 0, "step2");
    pulse_step(1'b1, 6, 0, "step3");
`endif

    // step in RUN (alone and on a tick) must not advance
    do_reset();
    run = 1'b1; cyc();               // E0: enter RUN
    step = 1'b1; cyc(); step = 1'b0; // E1
    cyc(); cyc();                    // E2, E3
    step = 1'b1; cyc(); step = 1'b0; // E4: tick coincides with step
    cyc();                           // E5
    chk("coinc hex", hex, 2);
    chk("coinc tick", tick, 1);
    cyc(); cyc(); cyc();             // E6..E8
    chk("coinc hold hex", hex, 2);
    cyc();                           // E9
    chk("coinc next hex", hex, 3);

    // blank masks hex but steps keep counting
    do_reset();
    run = 1'b1; cyc();
    for (int i = 0; i < 5; i++) cyc(); // E1..E5
    chk("blank pre hex", hex, 2);
    blank = 1'b1; cyc();               // E6
    chk("blank latency hex", hex, 2);
    cyc();                             // E7
    chk("blanked hex", hex, 0);
    cyc(); cyc();                      // E8, E9
    chk("blanked tick", tick, 1);
    chk("blanked hex2", hex, 0);
    for (int i = 0; i < 4; i++) cyc(); // E10..E13
    chk("blanked hex3", hex, 0);
    blank = 1'b0; cyc();               // E14
    chk("unblank latency hex", hex, 0);
    cyc();                             // E15
    chk("unblank hex", hex, 4);

    // rst mid-RUN at pos 5, then restart
    do_reset();
    run = 1'b1; cyc();
    for (int i = 0; i < 17; i++) cyc(); // E1..E17
    chk("pre-rst hex", hex, 5);
    rst = 1'b1; cyc();
    chk("rst hex", hex, 0);
    chk("rst tick", tick, 0);
    chk("rst wrap", wrap, 0);
    rst = 1'b0; cyc();                  // IDLE -> RUN
    chk("restart hex", hex, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("restart pos1 hex", hex, 1);
    end
    cyc();
    chk("restart step hex", hex, 2);
    chk("restart step tick", tick, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
